// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read-only cache controller: valid/tag/data arrays, lookup, burst refill and flush.
// Single requester, single memory port, saturating hit/miss statistics.
module dm_cache_ctrl #(
  parameter int unsigned INDEX_W    = 4,
  parameter int unsigned WORD_OFF_W = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned WORDS = 1 << WORD_OFF_W;
  localparam int unsigned OFF_W = WORD_OFF_W + 2;
  localparam int unsigned TAG_W = 32 - OFF_W - INDEX_W;
  localparam logic [WORD_OFF_W-1:0] LAST_BEAT = WORD_OFF_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_WAIT,
    S_RESPOND,
    S_FLUSH
  } state_e;

  state_e                 state_q, state_d;
  logic [31:2]            addr_q, addr_d;
  logic [WORD_OFF_W-1:0]  beat_q, beat_d;
  logic                   flush_pending_q, flush_pending_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [CNT_W-1:0]       hit_count_q, hit_count_d;
  logic [CNT_W-1:0]       miss_count_q, miss_count_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            resp_data_q, resp_data_d;
  logic                   mem_req_valid_q, mem_req_valid_d;
  logic [31:0]            mem_req_addr_q, mem_req_addr_d;

  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            data_q [LINES][WORDS];

  logic [WORD_OFF_W-1:0]  a_word;
  logic [INDEX_W-1:0]     a_index;
  logic [TAG_W-1:0]       a_tag;
  logic                   lookup_hit;
  logic                   beat_we;
  logic                   last_beat;
  logic                   unused_byte_off;

  // Byte offset within a word never affects a word-granular read.
  assign unused_byte_off = ^req_addr[1:0];

  assign a_word     = addr_q[OFF_W-1:2];
  assign a_index    = addr_q[OFF_W +: INDEX_W];
  assign a_tag      = addr_q[31 -: TAG_W];
  assign lookup_hit = valid_q[a_index] && (tag_q[a_index] == a_tag);
  assign beat_we    = (state_q == S_REFILL_WAIT) && mem_resp_valid;
  assign last_beat  = beat_we && (beat_q == LAST_BEAT);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    beat_d          = beat_q;
    flush_pending_d = flush_pending_q || flush;
    valid_d         = valid_q;
    hit_count_d     = hit_count_q;
    miss_count_d    = miss_count_q;
    resp_data_d     = resp_data_q;
    mem_req_addr_d  = mem_req_addr_q;

    case (state_q)
      S_IDLE: begin
        if (flush_pending_q) begin
          state_d = S_FLUSH;
        end else if (req_valid && req_ready_q) begin
          addr_d  = req_addr[31:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
          resp_data_d = data_q[a_index][a_word];
          state_d     = S_RESPOND;
        end else begin
          if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
          mem_req_addr_d = {a_tag, a_index, OFF_W'(0)};
          state_d        = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = S_REFILL_WAIT;
        end
      end
      S_REFILL_WAIT: begin
        if (mem_resp_valid) begin
          beat_d = beat_q + WORD_OFF_W'(1);
          if (beat_q == LAST_BEAT) begin
            valid_d[a_index] = 1'b1;
            // The final beat is still in flight to the array, so bypass it.
            resp_data_d = (a_word == LAST_BEAT) ? mem_resp_data : data_q[a_index][a_word];
            state_d     = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        valid_d         = '0;
        flush_pending_d = flush;
        state_d         = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d     = (state_d == S_IDLE) && !flush_pending_d;
    resp_valid_d    = (state_d == S_RESPOND);
    mem_req_valid_d = (state_d == S_REFILL_REQ);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      beat_q          <= '0;
      flush_pending_q <= 1'b0;
      valid_q         <= '0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      beat_q          <= beat_d;
      flush_pending_q <= flush_pending_d;
      valid_q         <= valid_d;
      hit_count_q     <= hit_count_d;
      miss_count_q    <= miss_count_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (beat_we)   data_q[a_index][beat_q] <= mem_resp_data;
    if (last_beat) tag_q[a_index]          <= a_tag;
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed vector table, randomized reads against a line-level cache model,
// and a hand-written reset-during-refill sequence.
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        flush = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int failures = 0;

  // Reference cache: 16 lines x 4 words, 24-bit tags
  bit   [15:0] m_valid = '0;
  logic [23:0] m_tag  [16];
  logic [31:0] m_data [16][4];
  int          m_hits = 0;
  int          m_misses = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    int          stall;
    int          flush_beat;
    bit          exp_miss;
    logic [31:0] exp_data;
    logic [31:0] exp_line;
    int          exp_hits;
    int          exp_misses;
  } vec_t;

  vec_t vecs [7];

  dm_cache_ctrl #(.INDEX_W(4), .WORD_OFF_W(2), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .flush          (flush),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"},     32'(req_ready),     32'd0);
    check({tag, "_resp_valid"},    32'(resp_valid),    32'd0);
    check({tag, "_resp_data"},     resp_data,          32'd0);
    check({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_mem_req_addr"},  mem_req_addr,       32'd0);
    check({tag, "_hit_count"},     32'(hit_count),     32'd0);
    check({tag, "_miss_count"},    32'(miss_count),    32'd0);
  endtask

  // One read transaction; plays the memory side if the DUT requests a refill.
  // abort_beats >= 0 asserts reset after that many refill beats and ends the transaction.
  task automatic read_txn(input logic [31:0] addr, input logic [31:0] base, input bit rnd,
                          input int stall, input int gap, input int flush_beat, input int abort_beats,
                          output bit got_miss, output logic [31:0] got_data, output logic [31:0] got_line);
    logic [31:0] beats [4];
    logic [31:0] exp_data;
    logic [31:0] line;
    logic [23:0] tg;
    int          idx;
    int          w;
    int          n;
    bit          exp_miss;
    bit          flushed;

    idx  = int'(addr[7:4]);
    w    = int'(addr[3:2]);
    tg   = addr[31:8];
    line = {addr[31:4], 4'h0};
    for (int b = 0; b < 4; b++) beats[b] = rnd ? $urandom : base + 32'(b);
    exp_miss = !(m_valid[idx] && (m_tag[idx] == tg));
    exp_data = exp_miss ? beats[w] : m_data[idx][w];
    got_miss = 1'b0;
    got_data = '0;
    got_line = '0;
    flushed  = 1'b0;

    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    if (req_ready !== 1'b1) return;

    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;

    n = 1;
    while (resp_valid !== 1'b1 && mem_req_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end

    if (mem_req_valid === 1'b1) begin
      got_miss = 1'b1;
      got_line = mem_req_addr;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_mem_req_valid", 32'(mem_req_valid), 32'd1);
        check("stall_mem_req_addr",  mem_req_addr,       line);
        check("stall_req_ready",     32'(req_ready),     32'd0);
        check("stall_resp_valid",    32'(resp_valid),    32'd0);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (b == abort_beats) begin
          rst = 1'b1;
          #1;
          check_outputs_zero("rst_async");
          mem_resp_valid = 1'b1;
          mem_resp_data  = beats[b];
          @(negedge clk);
          check_outputs_zero("rst_held");
          rst = 1'b0;
          for (int k = b + 1; k < 4; k++) begin
            mem_resp_data = beats[k];
            @(negedge clk);
          end
          mem_resp_valid = 1'b0;
          m_valid  = '0;
          m_hits   = 0;
          m_misses = 0;
          return;
        end
        repeat (gap) @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = beats[b];
        if (b == flush_beat) begin
          flush   = 1'b1;
          flushed = 1'b1;
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
        flush          = 1'b0;
      end
      check("miss_resp_timing", 32'(resp_valid), 32'd1);
    end else if (resp_valid === 1'b1) begin
      check("hit_latency", 32'(n), 32'd2);
      check("hit_no_mem_req", 32'(mem_req_valid), 32'd0);
    end else begin
      check("txn_timeout_resp_valid", 32'(resp_valid), 32'd1);
      return;
    end

    got_data = resp_data;
    check("miss_vs_model", 32'(got_miss), 32'(exp_miss));
    check("data_vs_model", got_data, exp_data);
    if (got_miss) check("line_vs_model", got_line, line);

    if (exp_miss) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      for (int b = 0; b < 4; b++) m_data[idx][b] = beats[b];
      if (m_misses < 65535) m_misses++;
    end else begin
      if (m_hits < 65535) m_hits++;
    end
    if (flushed) m_valid = '0;

    @(negedge clk);
    check("resp_pulse",      32'(resp_valid), 32'd0);
    check("resp_data_hold",  resp_data,       exp_data);
    check("ready_after_resp", 32'(req_ready), 32'(!flushed));
    check("hit_count_model", 32'(hit_count),  32'(m_hits));
    check("miss_count_model", 32'(miss_count), 32'(m_misses));
  endtask

  initial begin
    bit          gm;
    logic [31:0] gd;
    logic [31:0] gl;

    //             addr          base          stall flush miss data          line          hits misses
    vecs[0] = '{32'h0000_1004, 32'h0000_00A0, 0, -1, 1'b1, 32'h0000_00A1, 32'h0000_1000, 0, 1};
    vecs[1] = '{32'h0000_100C, 32'h0000_0000, 0, -1, 1'b0, 32'h0000_00A3, 32'h0000_0000, 1, 1};
    vecs[2] = '{32'h0000_2000, 32'h0000_00B0, 5, -1, 1'b1, 32'h0000_00B0, 32'h0000_2000, 1, 2};
    vecs[3] = '{32'h0000_1000, 32'h0000_00C0, 1, -1, 1'b1, 32'h0000_00C0, 32'h0000_1000, 1, 3};
    vecs[4] = '{32'h0000_3008, 32'h0000_00D0, 0,  1, 1'b1, 32'h0000_00D2, 32'h0000_3000, 1, 4};
    vecs[5] = '{32'h0000_3008, 32'h0000_00E0, 0, -1, 1'b1, 32'h0000_00E2, 32'h0000_3000, 1, 5};
    vecs[6] = '{32'h0000_300C, 32'h0000_0000, 0, -1, 1'b0, 32'h0000_00E3, 32'h0000_0000, 2, 5};

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      read_txn(vecs[i].addr, vecs[i].base, 1'b0, vecs[i].stall, 0, vecs[i].flush_beat, -1, gm, gd, gl);
      check($sformatf("vec%0d_miss", i), 32'(gm), 32'(vecs[i].exp_miss));
      check($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
      if (vecs[i].exp_miss) check($sformatf("vec%0d_line", i), gl, vecs[i].exp_line);
      check($sformatf("vec%0d_hits", i),   32'(hit_count),  32'(vecs[i].exp_hits));
      check($sformatf("vec%0d_misses", i), 32'(miss_count), 32'(vecs[i].exp_misses));
    end

    // Small tag pool so hits, conflicts and refills all occur frequently.
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      int          fb;
      a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      read_txn(a, 32'd0, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), fb, -1, gm, gd, gl);
    end

    // Reset after two of four refill beats, then reissue the same read.
    read_txn(32'h0000_4010, 32'h0000_0070, 1'b0, 0, 0, -1, 2, gm, gd, gl);
    @(negedge clk);
    read_txn(32'h0000_4010, 32'h0000_00F0, 1'b0, 0, 1, -1, -1, gm, gd, gl);
    check("rst_refill_miss",   32'(gm),         32'd1);
    check("rst_refill_line",   gl,              32'h0000_4010);
    check("rst_refill_data",   gd,              32'h0000_00F0);
    check("rst_refill_misses", 32'(miss_count), 32'd1);
    check("rst_refill_hits",   32'(hit_count),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Controller for the direct-mapped read-only cache used by the core's fetch/load path. Owns the valid, tag and data arrays, and sequences lookup, miss refill and flush. Sits between one requester (core) and the memory port. Uses a valid/ready request side, a one-cycle response pulse, and a burst refill from memory.

Parameters:
INDEX_W, 4, log2 of number of lines (16 lines)
WORD_OFF_W, 2, log2 of 32-bit words per line (4 words/line)
CNT_W, 16, width of hit/miss statistics counters

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  controller can accept request
req_addr  in  32  byte address; [1:0] ignored
resp_valid  out  1  one-cycle pulse, read data valid
resp_data  out  32  read data
mem_req_valid  out  1  line refill request
mem_req_ready  in  1  memory accepts refill request
mem_req_addr  out  32  line-aligned refill address
mem_resp_valid  in  1  refill beat valid
mem_resp_data  in  32  refill beat data
flush  in  1  invalidate-all request (level or pulse)
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Address split: word = addr[WORD_OFF_W+1:2], index = next INDEX_W bits, tag = remaining upper bits (TAG_W = 30-WORD_OFF_W-INDEX_W).
- Reset (async, rst=1): state IDLE, all valid bits 0, beat counter 0, flush_pending 0, counters 0. While rst=1, all outputs are 0. Tag/data arrays are not reset.
- States: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND, FLUSH.
- IDLE: req_ready = !flush_pending. If flush_pending, go to FLUSH and accept no request. Else, on req_valid&&req_ready, latch addr and go to LOOKUP.
- LOOKUP (1 cycle): hit = valid[index] && tag match.
  - Hit: hit_count++, go to RESPOND.
  - Miss: miss_count++, go to REFILL_REQ.
- REFILL_REQ: mem_req_valid=1 and mem_req_addr = {tag,index,WORD_OFF_W+2 zeros}, both held stable until mem_req_ready. On handshake, go to REFILL_WAIT with beat counter 0.
- REFILL_WAIT: each mem_resp_valid writes mem_resp_data to data[index][beat], then beat++. Beats arrive in order, word 0 first. On the final beat (beat = 2^WORD_OFF_W-1), write tag[index], set valid[index]=1, go to RESPOND. No timeout.
- mem_resp_valid outside REFILL_WAIT is ignored.
- RESPOND: resp_valid=1 for exactly one cycle. resp_data = data[index][word] of the latched address, including a word written on the final refill beat. Next state IDLE. The requester has no backpressure on the response.
- Latency from request handshake at cycle N:
  - Hit: resp_valid at N+2; next request accepted at N+3.
  - Miss: RESPOND occurs the cycle after the final refill beat.
- resp_data holds its last value when resp_valid=0.
- Flush: flush=1 in any cycle sets flush_pending. In FLUSH (1 cycle), all valid bits clear and flush_pending clears; next state IDLE.
  - A refill in progress when flush arrives completes and responds normally, and is then invalidated.
  - flush held high re-pends every cycle, so req_ready stays 0 until flush drops.
- Counters saturate at all-ones and never wrap. Only reset clears them.
- Reset mid-refill: the refill aborts, the line remains invalid, and memory beats arriving after reset are ignored.
- Exactly one outstanding request and one outstanding refill at any time.

Test Plan:
- Cold miss: after reset, read 0x0000_1004. Required: mem_req_addr=0x0000_1000; after 4 beats (0xA0..0xA3), resp_data=0xA1; miss_count=1, hit_count=0.
- Hit: read 0x0000_100C after the cold-miss fill. Required: resp_valid exactly 2 cycles after handshake, resp_data=0xA3, no mem_req_valid, hit_count=1.
- Conflict: read 0x0000_2000, which has the same index and a different tag. Required: refill at 0x0000_2000. Then re-read 0x0000_1000. Required: a miss with a new refill.
- Memory backpressure: hold mem_req_ready=0 for 5 cycles. Required: mem_req_valid and mem_req_addr stay stable, no resp_valid, req_ready=0 throughout.
- Flush: pulse flush during REFILL_WAIT. Required: the pending read still responds with refill data; then FLUSH occurs; re-reading the same address misses.
- Reset mid-refill: assert rst after 2 of 4 beats, then release and reissue the read. Required: all outputs 0 during reset, a fresh full refill occurs, and counters restart at miss_count=1.
